timer_dev: RTL



---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_dev.sv | 112 +++++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the timer_dev countdown timer peripheral:
// register offsets, CTRL field positions, MODE values and FSM states.
package timer_pkg;

  // Byte offsets within the 16-byte register window
  localparam logic [3:0] CTRL_OFF   = 4'h0;
  localparam logic [3:0] PRESET_OFF = 4'h4;
  localparam logic [3:0] COUNT_OFF  = 4'h8;

  // CTRL field positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM_BIT   = 3;

  // MODE values; anything other than MODE_RELOAD behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot (level IRQ until acknowledged)
// and auto-reload (one-cycle periodic IRQ pulse) modes.
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pending;
  state_e      state;

  logic        hit;
  logic [3:0]  word_off;
  logic        ctrl_wr;
  logic        preset_wr;
  logic [31:0] ctrl_rd;

  // Address decode; byte-lane bits [1:0] are masked off
  always_comb begin
    hit       = (addr[31:4] == BASE_ADDR[31:4]);
    word_off  = addr[3:0] & 4'b1100;
    ctrl_wr   = we && hit && (word_off == CTRL_OFF);
    preset_wr = we && hit && (word_off == PRESET_OFF);
  end

  // Read mux and masked interrupt output
  always_comb begin
    ctrl_rd                          = '0;
    ctrl_rd[CTRL_EN_BIT]             = ctrl_en;
    ctrl_rd[CTRL_MODE_LSB +: 2]      = ctrl_mode;
    ctrl_rd[CTRL_IM_BIT]             = ctrl_im;
    rdata = '0;
    if (hit) begin
      case (word_off)
        CTRL_OFF:   rdata = ctrl_rd;
        PRESET_OFF: rdata = preset;
        COUNT_OFF:  rdata = count;
        default:    rdata = '0;
      endcase
    end
    irq = irq_pending & ctrl_im;
  end

  // Register file and countdown FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_mode   <= MODE_ONESHOT;
      ctrl_im     <= 1'b0;
      preset      <= '0;
      count       <= '0;
      irq_pending <= 1'b0;
      state       <= ST_IDLE;
    end else begin
      if (preset_wr) preset <= wdata;
      // Software acknowledge; a hardware set later in this block overrides it
      if (ctrl_wr || preset_wr) irq_pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (ctrl_en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_en) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count       <= '0;
            irq_pending <= 1'b1;
            state       <= ST_INT;
          end
        end
        ST_INT: begin
          if (ctrl_mode == MODE_RELOAD) begin
            irq_pending <= 1'b0;
            state       <= ST_LOAD;
          end else begin
            ctrl_en <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // CPU CTRL write placed last so it overrides the one-shot EN clear
      if (ctrl_wr) begin
        ctrl_en   <= wdata[CTRL_EN_BIT];
        ctrl_mode <= wdata[CTRL_MODE_LSB +: 2];
        ctrl_im   <= wdata[CTRL_IM_BIT];
      end
    end
  end

endmodule
